// File: rtl/nf_10g_pkg.sv
// -----------------------------------------------------------------------------
// nf_10g_pkg
// Shared definitions for the 10G flow-control (pause frame) logic.
//   pause_state_t     : state encoding of the pause generator FSM
//   XON_QUANTA        : quanta value carried by an XON (resume) request
//   is_strobe_state() : true in the states that emit a pause request strobe
// -----------------------------------------------------------------------------
package nf_10g_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_XOFF_SEND = 3'd1,
        ST_XOFF_HOLD = 3'd2,
        ST_XON_SEND  = 3'd3,
        ST_GAP       = 3'd4
    } pause_state_t;

    localparam logic [15:0] XON_QUANTA = 16'h0000;

    function automatic logic is_strobe_state(input pause_state_t s);
        return (s == ST_XOFF_SEND) || (s == ST_XON_SEND);
    endfunction

endpackage

// File: rtl/nf_sat_counter.sv
// -----------------------------------------------------------------------------
// nf_sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   i_clk        : clock
//   i_reset      : synchronous active-high reset, clears the count
//   i_load       : load i_load_value into the count (takes priority over i_inc)
//   i_load_value : value to load
//   i_inc        : count one event this cycle
//   o_count      : current count
// -----------------------------------------------------------------------------
module nf_sat_counter #(
    parameter int unsigned C_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [C_WIDTH-1:0] i_load_value,
    input  logic               i_inc,
    output logic [C_WIDTH-1:0] o_count
);

    logic [C_WIDTH-1:0] r_count;

    // Count register: once every bit is set further events are dropped so
    // software reading the statistic sees "at least this many" rather than a
    // small wrapped number.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_inc && (r_count != {C_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/nf_10g_pause_gen.sv
// -----------------------------------------------------------------------------
// nf_10g_pause_gen
// Watches RX buffer occupancy and asks the MAC to send 802.3x pause frames:
// XOFF when the buffer fills past a high watermark (re-sent periodically while
// the buffer stays full), XON once it drains below a low watermark, followed by
// an enforced quiet gap before another XOFF may be issued.
//   clk156              : single 156.25 MHz clock
//   areset_clk156       : synchronous active-high reset
//   enable              : flow-control enable; dropping it releases any pause
//   fill_level          : RX buffer occupancy, unsigned, sampled every cycle
//   s_axis_pause_tdata  : pause quanta for the MAC (held between strobes)
//   s_axis_pause_tvalid : one-cycle pause request strobe (no ready)
//   paused              : high while XOFF is in force
//   xoff_count          : saturating count of XOFF strobes
//   xon_count           : saturating count of XON strobes
// -----------------------------------------------------------------------------
module nf_10g_pause_gen
    import nf_10g_pkg::*;
#(
    parameter int unsigned C_COUNT_WIDTH    = 32,
    parameter int unsigned C_XOFF_THRESH    = 1024,
    parameter int unsigned C_XON_THRESH     = 512,
    parameter logic [15:0] C_PAUSE_QUANTA   = 16'hFFFF,
    parameter int unsigned C_REFRESH_CYCLES = 2048,
    parameter int unsigned C_MIN_GAP        = 16
) (
    input  logic                     clk156,
    input  logic                     areset_clk156,
    input  logic                     enable,
    input  logic [C_COUNT_WIDTH-1:0] fill_level,
    output logic [15:0]              s_axis_pause_tdata,
    output logic                     s_axis_pause_tvalid,
    output logic                     paused,
    output logic [31:0]              xoff_count,
    output logic [31:0]              xon_count
);

    // Invalid watermark or refresh settings are rejected at elaboration.
    if (C_XON_THRESH >= C_XOFF_THRESH) begin : g_bad_thresh
        $error("nf_10g_pause_gen: C_XON_THRESH must be below C_XOFF_THRESH");
    end
    if (C_REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("nf_10g_pause_gen: C_REFRESH_CYCLES must be at least 2");
    end

    localparam logic [C_COUNT_WIDTH-1:0] L_XOFF_LEVEL   = C_COUNT_WIDTH'(C_XOFF_THRESH);
    localparam logic [C_COUNT_WIDTH-1:0] L_XON_LEVEL    = C_COUNT_WIDTH'(C_XON_THRESH);
    localparam logic [31:0]              L_REFRESH_LOAD = 32'(C_REFRESH_CYCLES - 1);
    localparam logic [31:0]              L_GAP_LOAD     = (C_MIN_GAP == 0) ? 32'd0 : 32'(C_MIN_GAP - 1);
    localparam logic                     L_HAS_GAP      = (C_MIN_GAP != 0);

    pause_state_t r_state;
    pause_state_t w_next_state;
    logic [31:0]  r_refresh_timer;
    logic [31:0]  w_refresh_next;
    logic [31:0]  r_gap_timer;
    logic [31:0]  w_gap_next;
    logic [15:0]  r_tdata;
    logic [15:0]  w_tdata_next;
    logic         w_xoff_hit;
    logic         w_xon_hit;
    logic         w_xoff_strobe;
    logic         w_xon_strobe;

    // Threshold equality counts as a crossing in both directions.
    assign w_xoff_hit = (fill_level >= L_XOFF_LEVEL);
    assign w_xon_hit  = (fill_level <= L_XON_LEVEL);

    // Next-state and timer logic. tdata is loaded on entry to a send state so
    // it is already correct during the strobe cycle and then simply holds.
    always_comb begin
        w_next_state   = r_state;
        w_refresh_next = r_refresh_timer;
        w_gap_next     = r_gap_timer;
        w_tdata_next   = r_tdata;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_xoff_hit) begin
                    w_next_state = ST_XOFF_SEND;
                    w_tdata_next = C_PAUSE_QUANTA;
                end
            end
            ST_XOFF_SEND: begin
                w_next_state   = ST_XOFF_HOLD;
                w_refresh_next = L_REFRESH_LOAD;
            end
            ST_XOFF_HOLD: begin
                // Release beats refresh so a draining buffer is never re-paused.
                if (!enable || w_xon_hit) begin
                    w_next_state = ST_XON_SEND;
                    w_tdata_next = XON_QUANTA;
                end else if (r_refresh_timer == 32'd0) begin
                    w_next_state = ST_XOFF_SEND;
                    w_tdata_next = C_PAUSE_QUANTA;
                end else begin
                    w_refresh_next = r_refresh_timer - 32'd1;
                end
            end
            ST_XON_SEND: begin
                if (L_HAS_GAP) begin
                    w_next_state = ST_GAP;
                    w_gap_next   = L_GAP_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GAP: begin
                // Thresholds are deliberately ignored here to stop XON/XOFF chatter.
                if (r_gap_timer == 32'd0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_gap_next = r_gap_timer - 32'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, timers and held tdata. Reset drops straight to IDLE without an
    // XON: the peer's pause simply runs out according to its quanta.
    always_ff @(posedge clk156) begin
        if (areset_clk156) begin
            r_state         <= ST_IDLE;
            r_refresh_timer <= 32'd0;
            r_gap_timer     <= 32'd0;
            r_tdata         <= 16'h0000;
        end else begin
            r_state         <= w_next_state;
            r_refresh_timer <= w_refresh_next;
            r_gap_timer     <= w_gap_next;
            r_tdata         <= w_tdata_next;
        end
    end

    assign w_xoff_strobe = (r_state == ST_XOFF_SEND);
    assign w_xon_strobe  = (r_state == ST_XON_SEND);

    assign s_axis_pause_tvalid = is_strobe_state(r_state);
    assign s_axis_pause_tdata  = r_tdata;
    assign paused              = (r_state == ST_XOFF_SEND) || (r_state == ST_XOFF_HOLD);

    nf_sat_counter #(
        .C_WIDTH (32)
    ) u_xoff_count (
        .i_clk        (clk156),
        .i_reset      (areset_clk156),
        .i_load       (1'b0),
        .i_load_value (32'd0),
        .i_inc        (w_xoff_strobe),
        .o_count      (xoff_count)
    );

    nf_sat_counter #(
        .C_WIDTH (32)
    ) u_xon_count (
        .i_clk        (clk156),
        .i_reset      (areset_clk156),
        .i_load       (1'b0),
        .i_load_value (32'd0),
        .i_inc        (w_xon_strobe),
        .o_count      (xon_count)
    );

endmodule

// File: tb/tb_nf_10g_pause_gen.sv
// -----------------------------------------------------------------------------
// tb_nf_10g_pause_gen
// Scoreboard bench for nf_10g_pause_gen with XOFF=100, XON=50, REFRESH=1000,
// GAP=16. Each expected strobe (cycle number and tdata) is queued when the
// stimulus that should cause it is driven; a monitor pops and compares every
// strobe the DUT emits. A standalone nf_sat_counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_nf_10g_pause_gen;

    localparam int unsigned XOFF_T  = 100;
    localparam int unsigned XON_T   = 50;
    localparam int unsigned REFRESH = 1000;
    localparam int unsigned GAP     = 16;

    logic        clk156;
    logic        areset_clk156;
    logic        enable;
    logic [31:0] fill_level;
    logic [15:0] s_axis_pause_tdata;
    logic        s_axis_pause_tvalid;
    logic        paused;
    logic [31:0] xoff_count;
    logic [31:0] xon_count;

    logic        probeLoad;
    logic [31:0] probeValue;
    logic        probeInc;
    logic [31:0] probeCount;

    int checkCount = 0;
    int failCount  = 0;
    int cycleNum   = 0;

    typedef struct {
        int          cycle;
        logic [15:0] data;
    } expStrobe_t;

    expStrobe_t sbQueue[$];

    nf_10g_pause_gen #(
        .C_COUNT_WIDTH    (32),
        .C_XOFF_THRESH    (XOFF_T),
        .C_XON_THRESH     (XON_T),
        .C_PAUSE_QUANTA   (16'hFFFF),
        .C_REFRESH_CYCLES (REFRESH),
        .C_MIN_GAP        (GAP)
    ) dut (
        .clk156              (clk156),
        .areset_clk156       (areset_clk156),
        .enable              (enable),
        .fill_level          (fill_level),
        .s_axis_pause_tdata  (s_axis_pause_tdata),
        .s_axis_pause_tvalid (s_axis_pause_tvalid),
        .paused              (paused),
        .xoff_count          (xoff_count),
        .xon_count           (xon_count)
    );

    nf_sat_counter #(
        .C_WIDTH (32)
    ) u_satProbe (
        .i_clk        (clk156),
        .i_reset      (areset_clk156),
        .i_load       (probeLoad),
        .i_load_value (probeValue),
        .i_inc        (probeInc),
        .o_count      (probeCount)
    );

    // 10 ns clock
    initial begin
        clk156 = 1'b0;
        forever #5 clk156 = ~clk156;
    end

    // Cycle index: a strobe caused by an input driven at the negedge where
    // cycleNum==n is seen at the negedge where cycleNum==n+1.
    always @(posedge clk156) begin
        cycleNum <= cycleNum + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cycleNum);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [31:0] fill);
        areset_clk156 = rst;
        enable        = en;
        fill_level    = fill;
    endtask

    function automatic void pushStrobe(input int cyc, input logic [15:0] data);
        expStrobe_t e;
        e.cycle = cyc;
        e.data  = data;
        sbQueue.push_back(e);
    endfunction

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk156) begin
        if (s_axis_pause_tvalid === 1'b1) begin
            checkOutput("strobeExpected", 32'(sbQueue.size() > 0), 32'd1);
            if (sbQueue.size() > 0) begin
                expStrobe_t e;
                e = sbQueue.pop_front();
                checkOutput("strobeCycle", 32'(cycleNum), 32'(e.cycle));
                checkOutput("strobeData", {16'h0, s_axis_pause_tdata}, {16'h0, e.data});
            end
        end
    end

    initial begin
        int firstXoff;
        int xonStart;

        probeLoad  = 1'b0;
        probeValue = 32'd0;
        probeInc   = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd0);
        repeat (3) @(negedge clk156);

        checkOutput("resetTvalid", {31'd0, s_axis_pause_tvalid}, 32'd0);
        checkOutput("resetTdata", {16'h0, s_axis_pause_tdata}, 32'd0);
        checkOutput("resetPaused", {31'd0, paused}, 32'd0);
        checkOutput("resetXoffCount", xoff_count, 32'd0);
        checkOutput("resetXonCount", xon_count, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'd0);
        repeat (4) @(negedge clk156);

        // One below the XOFF watermark must not trigger.
        applyStimulus(1'b0, 1'b1, XOFF_T - 1);
        repeat (5) @(negedge clk156);
        checkOutput("belowThreshPaused", {31'd0, paused}, 32'd0);

        // Step to exactly the watermark.
        applyStimulus(1'b0, 1'b1, XOFF_T);
        firstXoff = cycleNum + 1;
        pushStrobe(firstXoff, 16'hFFFF);
        repeat (3) @(negedge clk156);
        checkOutput("xoffPaused", {31'd0, paused}, 32'd1);
        checkOutput("xoffCount1", xoff_count, 32'd1);
        checkOutput("xoffTdataHeld", {16'h0, s_axis_pause_tdata}, 32'h0000FFFF);

        // Hold full: refreshes every REFRESH+1 cycles, one above XON keeps pause.
        applyStimulus(1'b0, 1'b1, 32'd150);
        pushStrobe(firstXoff + int'(REFRESH) + 1, 16'hFFFF);
        pushStrobe(firstXoff + 2 * (int'(REFRESH) + 1), 16'hFFFF);
        while (cycleNum < firstXoff + int'(REFRESH) + 10) @(negedge clk156);
        applyStimulus(1'b0, 1'b1, XON_T + 1);
        while (cycleNum < firstXoff + 2 * (int'(REFRESH) + 1) + 5) @(negedge clk156);
        checkOutput("refreshXoffCount", xoff_count, 32'd3);
        checkOutput("refreshPaused", {31'd0, paused}, 32'd1);

        // Drain to exactly XON, then refill during the gap.
        applyStimulus(1'b0, 1'b1, XON_T);
        xonStart = cycleNum + 1;
        pushStrobe(xonStart, 16'h0000);
        @(negedge clk156);
        applyStimulus(1'b0, 1'b1, 32'd120);
        pushStrobe(xonStart + int'(GAP) + 2, 16'hFFFF);
        repeat (3) @(negedge clk156);
        checkOutput("xonPaused", {31'd0, paused}, 32'd0);
        checkOutput("xonCount1", xon_count, 32'd1);
        checkOutput("xonTdataHeld", {16'h0, s_axis_pause_tdata}, 32'd0);
        while (cycleNum < xonStart + int'(GAP) + 6) @(negedge clk156);
        checkOutput("postGapPaused", {31'd0, paused}, 32'd1);
        checkOutput("postGapXoffCount", xoff_count, 32'd4);

        // Dropping enable releases the pause; disabled, a full buffer is ignored.
        repeat (5) @(negedge clk156);
        applyStimulus(1'b0, 1'b0, 32'd120);
        pushStrobe(cycleNum + 1, 16'h0000);
        @(negedge clk156);
        applyStimulus(1'b0, 1'b0, 32'd200);
        repeat (40) @(negedge clk156);
        checkOutput("disabledPaused", {31'd0, paused}, 32'd0);
        checkOutput("disabledXonCount", xon_count, 32'd2);
        checkOutput("disabledXoffCount", xoff_count, 32'd4);

        // Re-enable, then reset in the hold state: no XON, everything clears.
        applyStimulus(1'b0, 1'b1, 32'd200);
        pushStrobe(cycleNum + 1, 16'hFFFF);
        repeat (5) @(negedge clk156);
        checkOutput("preResetXoffCount", xoff_count, 32'd5);
        applyStimulus(1'b1, 1'b1, 32'd200);
        @(negedge clk156);
        checkOutput("holdResetTvalid", {31'd0, s_axis_pause_tvalid}, 32'd0);
        checkOutput("holdResetTdata", {16'h0, s_axis_pause_tdata}, 32'd0);
        checkOutput("holdResetPaused", {31'd0, paused}, 32'd0);
        checkOutput("holdResetXoffCount", xoff_count, 32'd0);
        checkOutput("holdResetXonCount", xon_count, 32'd0);
        repeat (3) @(negedge clk156);

        // First non-reset cycle evaluates XOFF immediately, no gap.
        applyStimulus(1'b0, 1'b1, 32'd200);
        pushStrobe(cycleNum + 1, 16'hFFFF);
        repeat (3) @(negedge clk156);
        checkOutput("afterResetXoffCount", xoff_count, 32'd1);
        checkOutput("afterResetXonCount", xon_count, 32'd0);

        // Saturating counter: single increment, then preload near the top.
        probeInc = 1'b1;
        @(negedge clk156);
        probeInc = 1'b0;
        @(negedge clk156);
        checkOutput("satIncOne", probeCount, 32'd1);
        probeLoad  = 1'b1;
        probeValue = 32'hFFFF_FFFE;
        @(negedge clk156);
        probeLoad = 1'b0;
        probeInc  = 1'b1;
        repeat (3) @(negedge clk156);
        probeInc = 1'b0;
        @(negedge clk156);
        checkOutput("satHold", probeCount, 32'hFFFF_FFFF);

        checkOutput("pendingStrobes", 32'(sbQueue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
